// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the two requester handshakes and the registered register-file
// write port shared by the write arbiter.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Requester A (pipeline WB stage)
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;

    // Requester B (multi-cycle unit)
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;

    // Register-file write port and observability
    logic              Write_En;
    logic [ADDR_W-1:0] Write_addr;
    logic [DATA_W-1:0] Write_data;
    logic              b_forced;

    // Requester side: drives write requests, sees grants and the write port
    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  Write_En, Write_addr, Write_data, b_forced
    );

    // Arbiter side: accepts requests, drives grants and the write port
    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output Write_En, Write_addr, Write_data, b_forced
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between the WB stage (A, fixed
// priority) and the multi-cycle unit (B). A starvation guard forces one B
// grant after STARVE_LIMIT consecutive cycles in which B was held off.
// The write port is registered: a grant at edge N is presented during cycle
// N+1 and captured by the register file at edge N+1.
module regfile_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    regfile_write_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        NORMAL = 1'b0,
        B_PRI  = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              a_grant;
    logic              b_grant;
    logic              b_blocked;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;

    // Saturating increment: the counter never wraps past STARVE_LIMIT
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= CNT_MAX)
            return CNT_MAX;
        else
            return v + 1'b1;
    endfunction

    // Grant decode: priority follows the state, nothing is granted in reset
    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        if (Reset_n) begin
            if (state == NORMAL) begin
                a_grant = bus.a_valid;
                b_grant = bus.b_valid && !bus.a_valid;
            end else begin
                b_grant = bus.b_valid;
                a_grant = bus.a_valid && !bus.b_valid;
            end
        end
    end

    assign b_blocked  = bus.b_valid && !b_grant;
    assign cnt_inc    = sat_inc(starve_cnt);
    assign grant_addr = a_grant ? bus.a_addr : bus.b_addr;
    assign grant_data = a_grant ? bus.a_data : bus.b_data;

    assign bus.a_ready  = a_grant;
    assign bus.b_ready  = b_grant;
    assign bus.b_forced = (state == B_PRI);

    // Priority FSM with starvation counter; B_PRI lasts until B is served
    // or withdraws its request
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            case (state)
                NORMAL: begin
                    if (b_blocked) begin
                        starve_cnt <= cnt_inc;
                        if (cnt_inc == CNT_MAX)
                            state <= B_PRI;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                B_PRI: begin
                    if (b_grant || !bus.b_valid) begin
                        state      <= NORMAL;
                        starve_cnt <= '0;
                    end
                end
                default: begin
                    state      <= NORMAL;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

    // Registered write port; a granted write to r0 completes the handshake
    // but never enables the register file
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            bus.Write_En   <= 1'b0;
            bus.Write_addr <= '0;
            bus.Write_data <= '0;
        end else begin
            bus.Write_En <= (a_grant || b_grant) && (grant_addr != '0);
            if (a_grant || b_grant) begin
                bus.Write_addr <= grant_addr;
                bus.Write_data <= grant_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a table of per-cycle requests
// with hand-computed grants and write-port results, plus hand-written
// sequences for reset behaviour.
module tb_regfile_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic Clock = 1'b0;
    logic Reset_n = 1'b0;

    regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_write_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .STARVE_LIMIT(4)
    ) dut (
        .Clock(Clock),
        .Reset_n(Reset_n),
        .bus(bus)
    );

    always #5 Clock = ~Clock;

    // Register-file model fed by the arbiter's write port
    logic [DATA_W-1:0] rf [32];
    always @(posedge Clock) begin
        if (bus.Write_En) rf[bus.Write_addr] <= bus.Write_data;
    end

    typedef struct packed {
        logic              av;
        logic [ADDR_W-1:0] aa;
        logic [DATA_W-1:0] ad;
        logic              bv;
        logic [ADDR_W-1:0] ba;
        logic [DATA_W-1:0] bd;
        logic              ear;
        logic              ebr;
        logic              ebf;
        logic              ewe;
        logic [ADDR_W-1:0] ewa;
        logic [DATA_W-1:0] ewd;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                         input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
        bus.a_valid = av;
        bus.a_addr  = aa;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_addr  = ba;
        bus.b_data  = bd;
    endtask

    // One cycle: inputs already applied just after posedge, readys checked
    // at negedge, write port checked just after the following posedge
    task automatic run_vec(input vec_t v, input int idx);
        drive(v.av, v.aa, v.ad, v.bv, v.ba, v.bd);
        @(negedge Clock);
        check($sformatf("v%0d a_ready", idx), 64'(bus.a_ready), 64'(v.ear));
        check($sformatf("v%0d b_ready", idx), 64'(bus.b_ready), 64'(v.ebr));
        check($sformatf("v%0d b_forced", idx), 64'(bus.b_forced), 64'(v.ebf));
        @(posedge Clock);
        #1;
        check($sformatf("v%0d Write_En", idx), 64'(bus.Write_En), 64'(v.ewe));
        if (v.ewe) begin
            check($sformatf("v%0d Write_addr", idx), 64'(bus.Write_addr), 64'(v.ewa));
            check($sformatf("v%0d Write_data", idx), 64'(bus.Write_data), 64'(v.ewd));
        end
    endtask

    initial begin
        //           av aa  ad            bv ba  bd          ar br bf we wa  wd
        vecs[0]  = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[2]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd7, 32'h55, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h11};
        vecs[3]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd7, 32'h55, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h11};
        vecs[4]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd7, 32'h55, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h11};
        vecs[5]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd7, 32'h55, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h11};
        vecs[6]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd7, 32'h55, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h55};
        vecs[7]  = '{1'b1, 5'd1, 32'h12,       1'b1, 5'd8, 32'h66, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h12};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd8, 32'h66, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 32'h66};
        vecs[9]  = '{1'b1, 5'd9, 32'h1,        1'b1, 5'd9, 32'h2,  1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h1};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h2,  1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h2};
        vecs[11] = '{1'b1, 5'd0, 32'hFFFF,     1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h77, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[13] = '{1'b1, 5'd5, 32'hA0,       1'b1, 5'd6, 32'hB0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA0};
        vecs[14] = '{1'b1, 5'd5, 32'hA0,       1'b1, 5'd6, 32'hB0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA0};
        vecs[15] = '{1'b1, 5'd5, 32'hA1,       1'b0, 5'd6, 32'hB0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA1};
        vecs[16] = '{1'b1, 5'd5, 32'hA0,       1'b1, 5'd6, 32'hB0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA0};
        vecs[17] = '{1'b1, 5'd5, 32'hA0,       1'b1, 5'd6, 32'hB0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA0};
        vecs[18] = '{1'b1, 5'd5, 32'hA0,       1'b1, 5'd6, 32'hB0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA0};
        vecs[19] = '{1'b1, 5'd5, 32'hA0,       1'b1, 5'd6, 32'hB0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA0};
        vecs[20] = '{1'b1, 5'd5, 32'hA0,       1'b1, 5'd6, 32'hB0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd6, 32'hB0};
        vecs[21] = '{1'b1, 5'd5, 32'hA0,       1'b1, 5'd6, 32'hB1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA0};
        vecs[22] = '{1'b1, 5'd5, 32'hA0,       1'b1, 5'd6, 32'hB1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA0};
        vecs[23] = '{1'b1, 5'd5, 32'hA0,       1'b1, 5'd6, 32'hB1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA0};
        vecs[24] = '{1'b1, 5'd5, 32'hA0,       1'b1, 5'd6, 32'hB1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA0};
        vecs[25] = '{1'b1, 5'd5, 32'hA2,       1'b0, 5'd6, 32'hB1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'hA2};
        vecs[26] = '{1'b1, 5'd5, 32'hA3,       1'b1, 5'd6, 32'hB1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hA3};
        vecs[27] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};

        // Reset held two cycles with both requesters asserting
        Reset_n = 1'b0;
        drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 32'h33);
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("rst%0d a_ready", c), 64'(bus.a_ready), 64'd0);
            check($sformatf("rst%0d b_ready", c), 64'(bus.b_ready), 64'd0);
            @(posedge Clock);
            #1;
            check($sformatf("rst%0d Write_En", c), 64'(bus.Write_En), 64'd0);
            check($sformatf("rst%0d Write_addr", c), 64'(bus.Write_addr), 64'd0);
            check($sformatf("rst%0d Write_data", c), 64'(bus.Write_data), 64'd0);
            check($sformatf("rst%0d b_forced", c), 64'(bus.b_forced), 64'd0);
        end
        Reset_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Same-address contention: B's later grant holds the final value
        check("reg9 final", 64'(rf[9]), 64'h2);
        check("reg3 final", 64'(rf[3]), 64'hDEADBEEF);

        // Build up starvation, grant A, then reset the cycle after the grant
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'hC0);
        for (int c = 0; c < 3; c++) begin
            @(posedge Clock);
            #1;
        end
        check("pre-rst Write_En", 64'(bus.Write_En), 64'd1);
        check("pre-rst Write_addr", 64'(bus.Write_addr), 64'd4);
        Reset_n = 1'b0;
        @(negedge Clock);
        check("rst6 a_ready", 64'(bus.a_ready), 64'd0);
        check("rst6 b_ready", 64'(bus.b_ready), 64'd0);
        @(posedge Clock);
        #1;
        check("rst6 Write_En", 64'(bus.Write_En), 64'd0);
        check("rst6 Write_addr", 64'(bus.Write_addr), 64'd0);
        check("rst6 Write_data", 64'(bus.Write_data), 64'd0);
        check("rst6 b_forced", 64'(bus.b_forced), 64'd0);
        Reset_n = 1'b1;

        // A cleared counter needs four fresh blocked cycles before B_PRI
        for (int c = 0; c < 4; c++) begin
            @(negedge Clock);
            check($sformatf("post-rst%0d b_forced", c), 64'(bus.b_forced), 64'd0);
            check($sformatf("post-rst%0d a_ready", c), 64'(bus.a_ready), 64'd1);
            @(posedge Clock);
            #1;
        end
        @(negedge Clock);
        check("post-rst4 b_forced", 64'(bus.b_forced), 64'd1);
        check("post-rst4 b_ready", 64'(bus.b_ready), 64'd1);
        @(posedge Clock);
        #1;
        check("post-rst4 Write_addr", 64'(bus.Write_addr), 64'd6);
        check("post-rst4 Write_data", 64'(bus.Write_data), 64'hC0);

        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge Clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
